// File: rtl/dly_ld_sequencer_pkg.sv
// ============================================================
// dly_ld_sequencer_pkg : shared FSM encoding and delay field widths
// Rev 1.0
// ============================================================
`default_nettype none

package dly_ld_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int DLY_W    = 8;
  localparam int FINE_W   = 3;
  localparam int COARSE_W = 5;

endpackage

`default_nettype wire

// File: rtl/dly_ld_sequencer_if.sv
// ============================================================
// dly_ld_sequencer_if : load/set command handshake
// Rev 1.0
// ============================================================
`default_nettype none

interface dly_ld_sequencer_if #(
  parameter int ADDR_W = 5
);
  import dly_ld_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_set;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DLY_W-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_set, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_set, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/dly_ld_sequencer_shadow_regs.sv
// ============================================================
// dly_shadow_regs : per-lane shadow of last loaded delay, registered readback
// Rev 1.0
// ============================================================
`default_nettype none

module dly_shadow_regs
  import dly_ld_sequencer_pkg::*;
#(
  parameter int               NUM_LANES   = 10,
  parameter int               ADDR_W      = 5,
  parameter logic [DLY_W-1:0] DELAY_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DLY_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DLY_W-1:0]  rd_data
);

  logic [DLY_W-1:0] regs [NUM_LANES];
  logic [DLY_W-1:0] rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        regs[i] <= DELAY_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Addresses with no matching lane fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_mux = regs[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= DELAY_VALUE;
    end else begin
      rd_data <= rd_mux;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dly_ld_sequencer.sv
// ============================================================
// dly_ld_sequencer : loads per-lane fine delays, then applies them with one set pulse
// Rev 1.0
// ============================================================
`default_nettype none

module dly_ld_sequencer
  import dly_ld_sequencer_pkg::*;
#(
  parameter int               NUM_LANES     = 10,
  parameter int               ADDR_W        = 5,
  parameter logic [DLY_W-1:0] DELAY_VALUE   = '0,
  parameter int               SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dly_ld_sequencer_if.slave    cmd_if,
  output logic [DLY_W-1:0]     dly_data,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic                 dly_set,
  output logic [NUM_LANES-1:0] pending,
  output logic                 err_addr,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DLY_W-1:0]     rd_data
);

  localparam logic [ADDR_W:0] LANE_LIMIT  = (ADDR_W+1)'(NUM_LANES);
  localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           settle_cnt;
  logic [7:0]           settle_cnt_nxt;
  logic                 accept;
  logic                 addr_ok;
  logic                 set_go;
  logic                 load_ok;
  logic                 load_bad;
  logic [NUM_LANES-1:0] lane_sel;

  assign cmd_if.cmd_ready = (state == ST_IDLE) && !rst;
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign addr_ok          = {1'b0, cmd_if.cmd_addr} < LANE_LIMIT;
  assign set_go           = accept && cmd_if.cmd_set;
  assign load_ok          = accept && !cmd_if.cmd_set && addr_ok;
  assign load_bad         = accept && !cmd_if.cmd_set && !addr_ok;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_sel
      assign lane_sel[i] = load_ok && (cmd_if.cmd_addr == ADDR_W'(i));
    end
  endgenerate

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      ST_IDLE: begin
        if (set_go) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = SETTLE_INIT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 8'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          settle_cnt_nxt = settle_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Bus data and ld strobe are registered together so each lane samples a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_data <= DELAY_VALUE;
      dly_ld   <= '0;
      dly_set  <= 1'b0;
      err_addr <= 1'b0;
      pending  <= '0;
    end else begin
      dly_ld   <= lane_sel;
      dly_set  <= set_go;
      err_addr <= load_bad;
      if (load_ok) begin
        dly_data <= cmd_if.cmd_data;
      end
      if (set_go) begin
        pending <= '0;
      end else begin
        pending <= pending | lane_sel;
      end
    end
  end

  dly_shadow_regs #(
    .NUM_LANES   (NUM_LANES),
    .ADDR_W      (ADDR_W),
    .DELAY_VALUE (DELAY_VALUE)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_ok),
    .wr_addr (cmd_if.cmd_addr),
    .wr_data (cmd_if.cmd_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: doc/dly_ld_sequencer.md
Name: dly_ld_sequencer

Overview:
- Command-driven loader for a bank of pipelined fine-delay input stages.
- Accepts (lane, 8-bit delay) load commands and drives the shared delay bus with one-hot per-lane ld strobes.
- On a set command, issues one broadcast set pulse, so all staged values take effect in the same cycle, then holds off new commands for a settle window.
- Keeps a shadow copy of each lane's last loaded value for readback, plus a pending mask of lanes loaded but not yet set.

Parameters:
- NUM_LANES, 10, number of delay lanes driven (1..32).
- ADDR_W, 5, width of lane address; must satisfy 2**ADDR_W >= NUM_LANES.
- DELAY_VALUE, 0, 8-bit reset value of every shadow entry; matches the delay stages' reset value.
- SETTLE_CYCLES, 4, extra cycles cmd_ready stays low after the set pulse (0..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_set  in  1  1 = apply all staged loads (cmd_addr/cmd_data ignored); 0 = load command
- cmd_addr  in  ADDR_W  target lane for a load
- cmd_data  in  8  delay value (bits [7:3] coarse, [2:0] fine)
- dly_data  out  8  shared delay bus to all lanes
- dly_ld  out  NUM_LANES  one-hot load strobe, per lane
- dly_set  out  1  broadcast apply strobe
- pending  out  NUM_LANES  lanes loaded since the last set
- err_addr  out  1  one-cycle pulse: load addressed a lane >= NUM_LANES
- rd_addr  in  ADDR_W  shadow readback address
- rd_data  out  8  shadow value at rd_addr, registered

Behaviour:
- Reset values:
  - cmd_ready = 0 while rst is asserted; 1 in the first cycle after release.
  - dly_data = DELAY_VALUE; dly_ld = 0; dly_set = 0; err_addr = 0; pending = 0.
  - All shadow entries = DELAY_VALUE; rd_data = DELAY_VALUE.
- FSM states: IDLE, SETTLE.
  - cmd_ready = (state == IDLE) and not in reset.
  - A command is accepted when cmd_valid & cmd_ready.
- Load accepted in cycle N (IDLE):
  - At N+1, dly_data = cmd_data and dly_ld[cmd_addr] = 1 for exactly one cycle. Both are registered and aligned, because each lane samples the bus on its ld strobe.
  - At N+1, shadow[cmd_addr] = cmd_data and pending[cmd_addr] = 1.
  - The FSM stays in IDLE, so loads can be issued back-to-back every cycle.
  - dly_data holds its last value when no load is issued.
- Load to an out-of-range address (cmd_addr >= NUM_LANES):
  - The command is accepted.
  - No dly_ld bit asserts; shadow, pending and dly_data are unchanged.
  - err_addr pulses at N+1.
- Set accepted in cycle N:
  - At N+1, dly_set = 1 for one cycle, pending is cleared to 0, and the FSM enters SETTLE.
  - cmd_ready stays low for cycles N+1 through N+1+SETTLE_CYCLES inclusive, then the FSM returns to IDLE.
  - With SETTLE_CYCLES = 0, cmd_ready is low only at N+1.
  - A set with pending == 0 still pulses dly_set.
- dly_ld and dly_set never assert in the same cycle.
- Settle counter: 8-bit, loaded with SETTLE_CYCLES on entry to SETTLE and decremented each cycle. The FSM exits to IDLE on the cycle the counter reads 0.
- Readback: rd_data is registered with 1-cycle latency.
  - An out-of-range rd_addr returns 8'h00.
  - Reading the lane being written in the same cycle returns the old value; the new value is visible one cycle later.
- Reset during SETTLE or mid-stream: the FSM returns to IDLE, all outputs take their reset values and no strobe is emitted. In-flight commands are dropped.
- cmd_valid while cmd_ready = 0 is ignored; the requester holds it until accepted.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_SETTLE).
  - Delay field constants: DLY_W = 8, FINE_W = 3, COARSE_W = 5.
- One sub-module, dly_shadow_regs:
  - NUM_LANES x 8 register file with asynchronous reset to DELAY_VALUE.
  - One write port and one registered read port; returns 0 for out-of-range addresses.
- The FSM, settle counter, strobe generation and pending mask stay in the top module.

Test Plan:
- Reset release: immediately after release, cmd_ready = 1, dly_ld = 0, dly_set = 0, pending = 0; rd_addr = 3 gives rd_data = DELAY_VALUE one cycle later.
- Back-to-back loads: lane 2 = 8'h5B, lane 7 = 8'h13 in consecutive cycles. Expect dly_ld = 0x004 with dly_data = 5B, next cycle dly_ld = 0x080 with dly_data = 13; pending = 0x084; readback returns 5B and 13.
- Set with SETTLE_CYCLES = 4:
  - Set accepted at N -> dly_set = 1 only at N+1, pending = 0 at N+1.
  - cmd_ready is low for exactly 5 cycles (N+1..N+5) and high at N+6.
  - A cmd_valid load held during the window is accepted at N+6, with dly_ld at N+7.
- Out-of-range load: cmd_addr = 12 with NUM_LANES = 10 -> err_addr pulses once; dly_ld stays 0; pending, shadow and dly_data unchanged.
- Reset mid-settle: assert rst two cycles after dly_set -> cmd_ready = 0 during reset and 1 on the first cycle after release; shadow returns to DELAY_VALUE; no extra dly_set appears.
- SETTLE_CYCLES = 0: set followed by a held load -> cmd_ready low for one cycle only; the load's dly_ld appears two cycles after the set's dly_set.
